// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master transmitter slice.
//   state_t  : transaction FSM states
//   phase_t  : quarter-period phase of one SCL bit (Q0..Q3)
//   ST_*     : bit positions inside the 8-bit status word
//   RW_WRITE : R/W bit value appended to the address for a write
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    LOAD,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } phase_t;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_ADDR_NACK = 2;
  localparam int unsigned ST_DATA_NACK = 3;

  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_master_transmitter_if.sv
// Request/byte-stream side of the I2C master transmitter.
//   start    : 1-cycle pulse, begin a transaction when idle
//   slv_addr : 7-bit target address, captured on an accepted start
//   tx_data  : byte to send, qualified by tx_valid
//   tx_last  : marks tx_data as the final byte
//   tx_ready : 1-cycle pulse when the byte is accepted
//   status   : [0]busy [1]done [2]addr_nack [3]data_nack, [7:4]=0
// Modport master is taken by the I2C master block, slave by the byte source.
interface i2c_master_transmitter_if;
  logic       start;
  logic [6:0] slv_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] status;

  modport master (
    input  start, slv_addr, tx_data, tx_valid, tx_last,
    output tx_ready, status
  );

  modport slave (
    output start, slv_addr, tx_data, tx_valid, tx_last,
    input  tx_ready, status
  );
endinterface

// File: rtl/i2c_bit_timer.sv
// Quarter-period timer for one SCL bit.
//   clk, reset : system clock, async active-low reset
//   run_i      : 0 clears the timer to Q0 / count 0
//   scl_i      : bus SCL level, used to detect slave clock stretching
//   phase_o    : current quarter (Q0..Q3)
//   qtr_tick_o : last clock of the current quarter
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned QTR = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   run_i,
  input  logic   scl_i,
  output phase_t phase_o,
  output logic   qtr_tick_o
);
  localparam int unsigned   CW   = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  phase_t        phase_q, phase_d;
  logic          hold;

  // While SCL should be high, a slave holding it low freezes the count.
  assign hold       = ((phase_q == Q2) || (phase_q == Q3)) && !scl_i;
  assign qtr_tick_o = (cnt_q == LAST) && !hold;
  assign phase_o    = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (qtr_tick_o) begin
      cnt_d   = '0;
      phase_d = phase_t'(phase_q + 2'd1);
    end else if (!hold) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/i2c_master_transmitter.sv
// I2C master transmitter: START, 7-bit address + W, 1..N data bytes from a
// valid/ready source with ACK check per byte, then STOP.
//   clk, reset : system clock, async active-low reset
//   bus        : start/address/byte-stream/status handshake (master modport)
//   sda, scl   : open-drain bus lines, driven only to 0 or released (Z)
module i2c_master_transmitter
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned CLOCK_SPD = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  i2c_master_transmitter_if.master bus,
  inout  wire                      sda,
  inout  wire                      scl
);
  localparam int unsigned QTR = CLK_FREQ / (4 * CLOCK_SPD);

  state_t     state_q, state_d;
  phase_t     phase;
  logic       qtr_tick, run, bit_end;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       last_q, last_d;
  logic       ack_q, ack_d;
  logic       addr_nack_q, addr_nack_d;
  logic       data_nack_q, data_nack_d;
  logic       done_q, done_d;
  logic       sda_oe, scl_oe;

  // Every state starts its timing at Q0: the timer is cleared in states that
  // do not time quarters and on every state change. Bit-state changes happen
  // on the Q3 tick, where the clear equals the natural wrap.
  assign run     = !((state_q == IDLE) || (state_q == LOAD)) && (state_d == state_q);
  assign bit_end = qtr_tick && (phase == Q3);

  i2c_bit_timer #(.QTR(QTR)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run),
    .scl_i      (scl),
    .phase_o    (phase),
    .qtr_tick_o (qtr_tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.start)                        state_d = START;
      START:    if (qtr_tick)                         state_d = ADDR;
      ADDR:     if (bit_end && (bitcnt_q == 3'd7))    state_d = ADDR_ACK;
      ADDR_ACK: if (bit_end)                          state_d = ack_q ? STOP : LOAD;
      LOAD:     if (bus.tx_valid)                     state_d = DATA;
      DATA:     if (bit_end && (bitcnt_q == 3'd7))    state_d = DATA_ACK;
      DATA_ACK: if (bit_end)                          state_d = (ack_q || last_q) ? STOP : LOAD;
      STOP:     if (bit_end)                          state_d = IDLE;
    endcase
  end

  // Outputs: line drivers, byte handshake
  always_comb begin
    sda_oe       = 1'b0;
    scl_oe       = 1'b0;
    bus.tx_ready = 1'b0;
    unique case (state_q)
      IDLE: ;
      START: sda_oe = 1'b1;
      ADDR, DATA: begin
        sda_oe = !shift_q[7];
        scl_oe = (phase == Q0) || (phase == Q1);
      end
      ADDR_ACK, DATA_ACK: scl_oe = (phase == Q0) || (phase == Q1);
      LOAD: begin
        scl_oe       = 1'b1;
        bus.tx_ready = bus.tx_valid;
      end
      STOP: begin
        sda_oe = (phase != Q3);
        scl_oe = (phase == Q0) || (phase == Q1);
      end
    endcase
  end

  always_comb begin
    bus.status               = '0;
    bus.status[ST_BUSY]      = (state_q != IDLE);
    bus.status[ST_DONE]      = done_q;
    bus.status[ST_ADDR_NACK] = addr_nack_q;
    bus.status[ST_DATA_NACK] = data_nack_q;
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

  // Datapath: shift register, bit counter, ACK sample, flags
  always_comb begin
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    last_d      = last_q;
    ack_d       = ack_q;
    addr_nack_d = addr_nack_q;
    data_nack_d = data_nack_q;
    done_d      = 1'b0;
    // The Q2 tick is the start of Q3: SCL is high, sample the ACK slot.
    if (qtr_tick && (phase == Q2) && ((state_q == ADDR_ACK) || (state_q == DATA_ACK)))
      ack_d = sda;
    unique case (state_q)
      IDLE: if (bus.start) begin
        shift_d     = {bus.slv_addr, RW_WRITE};
        bitcnt_d    = '0;
        addr_nack_d = 1'b0;
        data_nack_d = 1'b0;
      end
      // Counter wraps 7 -> 0, leaving it ready for the next byte.
      ADDR, DATA: if (bit_end) begin
        shift_d  = {shift_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
      end
      ADDR_ACK: if (bit_end && ack_q) addr_nack_d = 1'b1;
      LOAD: if (bus.tx_valid) begin
        shift_d = bus.tx_data;
        last_d  = bus.tx_last;
      end
      DATA_ACK: if (bit_end && ack_q) data_nack_d = 1'b1;
      STOP: if (bit_end) done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      ack_q       <= 1'b0;
      addr_nack_q <= 1'b0;
      data_nack_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      addr_nack_q <= addr_nack_d;
      data_nack_q <= data_nack_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_transmitter.sv
// Directed bench for i2c_master_transmitter with a pulled-up bus and a
// simple slave receiver model (ACK/NACK per byte, optional SCL stretch).
module tb_i2c_master_transmitter;
  import i2c_pkg::*;

  logic clk;
  logic reset;
  wire  sda_w;
  wire  scl_w;

  i2c_master_transmitter_if bus ();

  i2c_master_transmitter #(
    .CLK_FREQ  (4000000),
    .CLOCK_SPD (100000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sda   (sda_w),
    .scl   (scl_w)
  );

  pullup (sda_w);
  pullup (scl_w);

  bit bfm_sda_low;
  bit bfm_scl_low;
  assign sda_w = bfm_sda_low ? 1'b0 : 1'bz;
  assign scl_w = bfm_scl_low ? 1'b0 : 1'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Slave receiver model and bus log
  logic [7:0]  rx[$];
  int unsigned rises[$];
  int unsigned falls[$];
  int unsigned stop_cnt, ready_cnt;
  bit          prev_sda, prev_scl;
  int unsigned bit_cnt, byte_idx;
  logic [7:0]  sh;
  bit          nack_addr;
  int unsigned nack_data_idx;

  always @(negedge clk) begin
    if (bus.tx_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    if (prev_scl && scl_w && prev_sda && !sda_w) begin
      bit_cnt  <= 0;
      byte_idx <= 0;
    end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!prev_scl && scl_w) begin
      rises.push_back(cyc);
      if (bit_cnt < 8) begin
        sh      <= {sh[6:0], sda_w};
        bit_cnt <= bit_cnt + 1;
      end
    end else if (prev_scl && !scl_w) begin
      falls.push_back(cyc);
      if (bit_cnt == 8) begin
        rx.push_back(sh);
        bfm_sda_low <= !((byte_idx == 0 && nack_addr) ||
                         (nack_data_idx != 0 && byte_idx == nack_data_idx));
        bit_cnt  <= 9;
        byte_idx <= byte_idx + 1;
      end else if (bit_cnt == 9) begin
        bfm_sda_low <= 1'b0;
        bit_cnt     <= 0;
      end
    end
    prev_sda <= sda_w;
    prev_scl <= scl_w;
  end

  logic [7:0]  tx_bytes [0:3];
  int unsigned ready_base, stop_base;
  logic [7:0]  st;
  bit          ok;
  bit          busy0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rx.delete();
    rises.delete();
    falls.delete();
    ready_base = ready_cnt;
    stop_base  = stop_cnt;
  endtask

  task automatic pulse_start(input logic [6:0] addr);
    @(posedge clk); #1;
    bus.slv_addr = addr;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output logic [7:0] s, output bit fin);
    fin = 1'b0;
    s   = '0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.status[ST_DONE] === 1'b1) begin
        fin = 1'b1;
        s   = bus.status;
        break;
      end
    end
  endtask

  task automatic run_txn(input logic [6:0] addr, input int unsigned n, input int unsigned withhold,
                         output logic [7:0] s, output bit fin, output bit busy_seen);
    bit over;
    over = 1'b0;
    clear_log();
    pulse_start(addr);
    @(negedge clk);
    busy_seen = bus.status[ST_BUSY];
    fork
      begin
        for (int unsigned i = 0; i < n && !over; i++) begin
          if (i == 0 && withhold != 0) begin
            for (int unsigned k = 0; k < 5000; k++) begin
              @(negedge clk);
              if (falls.size() >= 10) break;
            end
            repeat (withhold) @(posedge clk);
            #1;
          end
          bus.tx_data  = tx_bytes[i];
          bus.tx_last  = (i == n - 1);
          bus.tx_valid = 1'b1;
          for (int unsigned k = 0; k < 5000 && !over; k++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1) break;
          end
          if (!over) begin
            @(posedge clk); #1;
          end
        end
        bus.tx_valid = 1'b0;
      end
      begin
        wait_done(6000, s, fin);
        over = 1'b1;
      end
    join
  endtask

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.slv_addr  = '0;
    bus.tx_data   = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_last   = 1'b0;
    nack_addr     = 1'b0;
    nack_data_idx = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_status", 32'(bus.status), 32'h00);
    chk("reset_tx_ready", 32'(bus.tx_ready), 32'h0);
    chk("reset_sda", 32'(sda_w), 32'h1);
    chk("reset_scl", 32'(scl_w), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // 1: one byte, all ACKed
    tx_bytes[0] = 8'hA5;
    run_txn(7'h50, 1, 0, st, ok, busy0);
    chk("t1_busy", 32'(busy0), 32'h1);
    chk("t1_done", 32'(ok), 32'h1);
    chk("t1_status_at_done", 32'(st), 32'h02);
    chk("t1_nbytes", rx.size(), 2);
    if (rx.size() >= 2) begin
      chk("t1_addr_byte", 32'(rx[0]), 32'hA0);
      chk("t1_data_byte", 32'(rx[1]), 32'hA5);
    end
    if (rises.size() >= 2) chk("t1_scl_period", rises[1] - rises[0], 40);
    chk("t1_stop", stop_cnt - stop_base, 1);
    chk("t1_ready_pulses", ready_cnt - ready_base, 1);
    @(negedge clk);
    chk("t1_status_after", 32'(bus.status), 32'h00);

    // 2: address NACK
    nack_addr = 1'b1;
    tx_bytes[0] = 8'h77;
    run_txn(7'h3C, 1, 0, st, ok, busy0);
    nack_addr = 1'b0;
    chk("t2_done", 32'(ok), 32'h1);
    chk("t2_nbytes", rx.size(), 1);
    if (rx.size() >= 1) chk("t2_addr_byte", 32'(rx[0]), 32'h78);
    chk("t2_ready_pulses", ready_cnt - ready_base, 0);
    chk("t2_stop", stop_cnt - stop_base, 1);
    @(negedge clk);
    chk("t2_status_after", 32'(bus.status), 32'h04);

    // 3: three bytes, second data byte NACKed
    nack_data_idx = 2;
    tx_bytes[0] = 8'h11;
    tx_bytes[1] = 8'h22;
    tx_bytes[2] = 8'h33;
    run_txn(7'h21, 3, 0, st, ok, busy0);
    nack_data_idx = 0;
    chk("t3_done", 32'(ok), 32'h1);
    chk("t3_ready_pulses", ready_cnt - ready_base, 2);
    chk("t3_nbytes", rx.size(), 3);
    if (rx.size() >= 3) chk("t3_byte2", 32'(rx[2]), 32'h22);
    chk("t3_stop", stop_cnt - stop_base, 1);
    @(negedge clk);
    chk("t3_status_after", 32'(bus.status), 32'h08);

    // 4: source withholds the byte 200 clocks in LOAD
    tx_bytes[0] = 8'h3E;
    run_txn(7'h0F, 1, 200, st, ok, busy0);
    chk("t4_done", 32'(ok), 32'h1);
    if (rises.size() >= 10 && falls.size() >= 10)
      chk("t4_scl_low_stretch", 32'((rises[9] - falls[9] >= 220) && (rises[9] - falls[9] <= 225)), 32'h1);
    if (rx.size() >= 2) chk("t4_data_byte", 32'(rx[1]), 32'h3E);
    else                chk("t4_nbytes", rx.size(), 2);

    // 5: slave stretches SCL during a Q2
    tx_bytes[0] = 8'h5A;
    fork
      run_txn(7'h2A, 1, 0, st, ok, busy0);
      begin
        for (int unsigned k = 0; k < 5000; k++) begin
          @(negedge clk);
          if (falls.size() >= 3) break;
        end
        bfm_scl_low = 1'b1;
        repeat (77) @(posedge clk);
        #1;
        bfm_scl_low = 1'b0;
      end
    join
    chk("t5_done", 32'(ok), 32'h1);
    if (rises.size() >= 3 && falls.size() >= 4) begin
      chk("t5_low_len", 32'(rises[2] - falls[2] >= 77), 32'h1);
      chk("t5_high_len", falls[3] - rises[2], 20);
    end
    chk("t5_nbytes", rx.size(), 2);
    if (rx.size() >= 2) begin
      chk("t5_addr_byte", 32'(rx[0]), 32'h54);
      chk("t5_data_byte", 32'(rx[1]), 32'h5A);
    end

    // 6: reset during data bit 4, then a clean transaction
    clear_log();
    bus.tx_data  = 8'hC3;
    bus.tx_last  = 1'b1;
    bus.tx_valid = 1'b1;
    pulse_start(7'h11);
    for (int unsigned k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (falls.size() >= 14) break;
    end
    chk("t6_reached_bit4", 32'(falls.size() >= 14), 32'h1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_sda_released", 32'(sda_w), 32'h1);
    chk("t6_scl_released", 32'(scl_w), 32'h1);
    chk("t6_status_clear", 32'(bus.status), 32'h00);
    chk("t6_tx_ready_clear", 32'(bus.tx_ready), 32'h0);
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    tx_bytes[0] = 8'h99;
    run_txn(7'h22, 1, 0, st, ok, busy0);
    chk("t6_restart_done", 32'(ok), 32'h1);
    chk("t6_restart_status", 32'(st), 32'h02);
    chk("t6_restart_nbytes", rx.size(), 2);
    if (rx.size() >= 2) begin
      chk("t6_restart_addr", 32'(rx[0]), 32'h44);
      chk("t6_restart_data", 32'(rx[1]), 32'h99);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
